// File: rtl/mem_pkg.sv
// Shared definitions for the banked byte-lane memory.
package mem_pkg;

    // Controller states: INIT sweeps the array with the init value, IDLE serves requests.
    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_e;

    // Access size encoding carried on req_byte.
    localparam logic ACC_WORD = 1'b0;
    localparam logic ACC_BYTE = 1'b1;

endpackage

// File: rtl/byte_lane_ram.sv
// One 8-bit lane of the banked memory: synchronous write, registered read.
module byte_lane_ram #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    input  logic          re,
    output logic [7:0]    rdata
);

    // Storage is intentionally not reset; the init engine defines its contents.
    logic [7:0] mem [DEPTH];

    // Write port: one byte per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port: data registered so it lines up with the one-cycle response.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/banked_mem.sv
// Byte-addressable memory built from DATA_W/8 byte lanes, with a power-up init engine
// and a fully pipelined single-cycle-latency request/response port.
module banked_mem #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 6,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    import mem_pkg::*;

    localparam int unsigned LANES   = DATA_W / 8;
    localparam int unsigned LANE_W  = $clog2(LANES);
    localparam int unsigned WORD_AW = ADDR_W - LANE_W;
    localparam int unsigned DEPTH   = 2 ** WORD_AW;

    localparam logic [WORD_AW-1:0] LAST_IDX = WORD_AW'(DEPTH - 1);

    // Controller state and init sweep index.
    state_e             state_q, state_d;
    logic [WORD_AW-1:0] idx_q, idx_d;
    logic               in_init;

    // Request decode.
    logic [LANE_W-1:0]  req_lane;
    logic [WORD_AW-1:0] req_word;
    logic               accept;
    logic               misaligned;

    // Lane RAM controls.
    logic [WORD_AW-1:0] ram_addr;
    logic               ram_re;
    logic               lane_we    [LANES];
    logic [7:0]         lane_wdata [LANES];
    logic [7:0]         lane_rdata [LANES];

    // Response pipeline stage.
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic               rsp_read_q;
    logic               rsp_byte_q;
    logic [LANE_W-1:0]  rsp_lane_q;

    // Formatted read data.
    logic [7:0]         sel_byte;
    logic [DATA_W-1:0]  word_data;

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------

    // State register: reset restarts the init sweep from word 0.
    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            state_q <= INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: sweep to the last word then idle; clr only honoured while idle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            INIT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + WORD_AW'(1);
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d = INIT;
                    idx_d   = '0;
                end
            end
        endcase
    end

    // FSM outputs: requests are refused while initialising or while clr is asserted.
    always_comb begin
        in_init   = (state_q == INIT);
        busy      = in_init;
        req_ready = (state_q == IDLE) && !clr;
    end

    // ------------------------------------------------------------------
    // Request decode and lane steering
    // ------------------------------------------------------------------

    // Split the byte address into lane select and word index; flag unaligned word accesses.
    always_comb begin
        req_lane   = req_addr[LANE_W-1:0];
        req_word   = req_addr[ADDR_W-1:LANE_W];
        accept     = req_valid && req_ready;
        misaligned = (req_byte == ACC_WORD) && (req_lane != '0);
    end

    // Drive lane write enables/data from either the init sweep or an accepted write.
    always_comb begin
        ram_addr = in_init ? idx_q : req_word;
        ram_re   = accept && !req_write && !misaligned;
        for (int i = 0; i < LANES; i++) begin
            lane_we[i]    = 1'b0;
            lane_wdata[i] = req_wdata[7:0];
            if (in_init) begin
                lane_we[i]    = 1'b1;
                lane_wdata[i] = INIT_VAL[8*i +: 8];
            end else if (accept && req_write && !misaligned) begin
                if (req_byte == ACC_BYTE) begin
                    // Byte writes replicate wdata[7:0]; only the addressed lane is enabled.
                    lane_we[i] = (req_lane == LANE_W'(i));
                end else begin
                    lane_we[i]    = 1'b1;
                    lane_wdata[i] = req_wdata[8*i +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        byte_lane_ram #(
            .DEPTH (DEPTH),
            .AW    (WORD_AW)
        ) u_ram (
            .clk   (clk),
            .we    (lane_we[g]),
            .addr  (ram_addr),
            .wdata (lane_wdata[g]),
            .re    (ram_re),
            .rdata (lane_rdata[g])
        );
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------

    // Response stage: remembers what kind of reply the lane read data must be shaped into.
    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_read_q  <= 1'b0;
            rsp_byte_q  <= 1'b0;
            rsp_lane_q  <= '0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && misaligned;
            rsp_read_q  <= ram_re;
            rsp_byte_q  <= req_byte;
            rsp_lane_q  <= req_lane;
        end
    end

    // Shape read data: whole word, or the addressed byte sign-extended; zero otherwise.
    always_comb begin
        sel_byte  = '0;
        word_data = '0;
        for (int i = 0; i < LANES; i++) begin
            word_data[8*i +: 8] = lane_rdata[i];
            if (rsp_lane_q == LANE_W'(i)) begin
                sel_byte = lane_rdata[i];
            end
        end
        rsp_valid = rsp_valid_q;
        rsp_err   = rsp_err_q;
        rsp_rdata = '0;
        if (rsp_valid_q && rsp_read_q) begin
            if (rsp_byte_q == ACC_BYTE) begin
                rsp_rdata = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
            end else begin
                rsp_rdata = word_data;
            end
        end
    end

    // Invariants of the port protocol.
    a_no_ready_when_busy: assert property (@(posedge clk) disable iff (proc_rst)
        busy |-> !req_ready);
    a_err_has_zero_data: assert property (@(posedge clk) disable iff (proc_rst)
        rsp_err |-> (rsp_valid && rsp_rdata == '0));

endmodule

// File: tb/tb_banked_mem.sv
// Scoreboard bench for banked_mem (DATA_W=16, ADDR_W=6, INIT_VAL=0).
module tb_banked_mem;

    logic        clk = 1'b0;
    logic        proc_rst;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic        err;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    banked_mem #(
        .DATA_W   (16),
        .ADDR_W   (6),
        .INIT_VAL (16'h0000)
    ) dut (
        .clk       (clk),
        .proc_rst  (proc_rst),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata %h err %b expected no response",
                         rsp_rdata, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, " rdata"}, {16'h0, rsp_rdata}, {16'h0, mon_e.data});
                chk({mon_e.name, " err"}, {31'h0, rsp_err}, {31'h0, mon_e.err});
            end
        end
    end

    // Present one request, wait (bounded) for acceptance, and queue its expected reply.
    task automatic issue(input string nm, input logic wr, input logic by, input logic [5:0] a,
                         input logic [15:0] wd, input logic [15:0] exp_d, input logic exp_e);
        int n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_byte  = by;
        req_addr  = a;
        req_wdata = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            chk({nm, " ready_timeout"}, {31'h0, req_ready}, 32'h1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            e.data = exp_d;
            e.err  = exp_e;
            e.name = nm;
            exp_q.push_back(e);
            #1;
            req_valid = 1'b0;
        end
    endtask

    // Count negedge samples with busy high (bounded); optionally pulse clr at sample clr_at.
    task automatic count_busy(input string nm, input int clr_at);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            clr = (n == clr_at);
            @(negedge clk);
        end
        clr = 1'b0;
        chk({nm, " busy_cycles"}, n, 32);
        chk({nm, " ready_after"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        proc_rst  = 1'b1;
        clr       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state.
        @(negedge clk);
        chk("rst busy", {31'h0, busy}, 32'h1);
        chk("rst req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst rsp_rdata", {16'h0, rsp_rdata}, 32'h0);

        @(negedge clk);
        proc_rst = 1'b0;
        count_busy("init", -1);

        issue("rd 3E", 1'b0, 1'b0, 6'h3E, 16'h0000, 16'h0000, 1'b0);

        // Word write then byte reads with sign extension.
        issue("wr 04", 1'b1, 1'b0, 6'h04, 16'hA5F0, 16'h0000, 1'b0);
        issue("brd 04", 1'b0, 1'b1, 6'h04, 16'h0000, 16'hFFF0, 1'b0);
        issue("brd 05", 1'b0, 1'b1, 6'h05, 16'h0000, 16'hFFA5, 1'b0);

        // Byte write (upper wdata bits ignored) then back-to-back word read.
        issue("bwr 05", 1'b1, 1'b1, 6'h05, 16'h117B, 16'h0000, 1'b0);
        issue("rd 04 after bwr", 1'b0, 1'b0, 6'h04, 16'h0000, 16'h7BF0, 1'b0);

        // Misaligned word accesses leave memory alone and flag an error.
        issue("wr 08", 1'b1, 1'b0, 6'h08, 16'h5A3C, 16'h0000, 1'b0);
        issue("wr 09 misaligned", 1'b1, 1'b0, 6'h09, 16'hFFFF, 16'h0000, 1'b1);
        issue("rd 08 unchanged", 1'b0, 1'b0, 6'h08, 16'h0000, 16'h5A3C, 1'b0);
        issue("rd 07 misaligned", 1'b0, 1'b0, 6'h07, 16'h0000, 16'h0000, 1'b1);
        issue("brd 09 positive", 1'b0, 1'b1, 6'h09, 16'h0000, 16'h005A, 1'b0);
        issue("brd 08 positive", 1'b0, 1'b1, 6'h08, 16'h0000, 16'h003C, 1'b0);
        issue("wr 0C", 1'b1, 1'b0, 6'h0C, 16'hBEEF, 16'h0000, 1'b0);

        // clr with a simultaneous request: request refused, memory re-initialised.
        @(negedge clk);
        clr       = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 6'h0C;
        req_wdata = 16'h1111;
        #1;
        chk("clr req_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        clr       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        // A second clr mid-sweep must not restart it.
        count_busy("clr", 5);
        for (int w = 0; w < 32; w++) begin
            issue("rd after clr", 1'b0, 1'b0, 6'(w * 2), 16'h0000, 16'h0000, 1'b0);
        end

        // Reset mid-traffic discards the pending response.
        issue("rd before rst", 1'b0, 1'b0, 6'h04, 16'h0000, 16'h0000, 1'b0);
        proc_rst = 1'b1;
        #1;
        chk("traffic rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("traffic rst busy", {31'h0, busy}, 32'h1);
        chk("traffic rst req_ready", {31'h0, req_ready}, 32'h0);
        exp_q.delete();
        @(negedge clk);
        proc_rst = 1'b0;
        count_busy("traffic rst", -1);

        // Reset at init index 10 restarts a full sweep.
        proc_rst = 1'b1;
        @(negedge clk);
        proc_rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        proc_rst = 1'b1;
        @(negedge clk);
        proc_rst = 1'b0;
        count_busy("idx10 rst", -1);
        issue("rd 3E after idx10", 1'b0, 1'b0, 6'h3E, 16'h0000, 16'h0000, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/banked_mem.md
BANKED_MEM -- requirements
Module: banked_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 16: word width in bits; must be a multiple of 8 and at least 16.
REQ-002 SHALL have parameter ADDR_W, default 6: byte-address width; DEPTH = 2^ADDR_W / (DATA_W/8) words (default 32).
REQ-003 SHALL have parameter INIT_VAL, default 0: DATA_W-bit value written to every word by the init engine.
REQ-004 SHALL have one clock and asynchronous active-high reset: clk  in  1  clock, all state updates on rising edge.
REQ-005 SHALL have port proc_rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port clr  in  1  pulse; restarts the init engine from IDLE.
REQ-007 SHALL have port req_valid  in  1  access request present.
REQ-008 SHALL have port req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-009 SHALL have port req_write  in  1  1 = write, 0 = read.
REQ-010 SHALL have port req_byte  in  1  1 = byte access, 0 = full-word access.
REQ-011 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-012 SHALL have port req_wdata  in  DATA_W  write data; byte writes use bits [7:0].
REQ-013 SHALL have port rsp_valid  out  1  one-cycle response pulse.
REQ-014 SHALL have port rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
REQ-015 SHALL have port rsp_err  out  1  misaligned-access flag, valid with rsp_valid.
REQ-016 SHALL have port busy  out  1  init engine active.

Function
REQ-017 SHALL be a two-state FSM: INIT and IDLE.
REQ-018 In INIT, SHALL write INIT_VAL to word index 0, 1, ..., DEPTH-1, one word per cycle, then enter IDLE; busy=1 and req_ready=0 throughout INIT.
REQ-019 In IDLE, req_ready SHALL equal !clr (combinational); clr=1 in IDLE SHALL enter INIT at index 0 next cycle and the simultaneous request SHALL NOT be accepted.
REQ-020 clr during INIT SHALL be ignored and SHALL NOT restart the sequence.
REQ-021 Accepted requests (req_valid and req_ready) SHALL be handled one per cycle, fully pipelined; rsp_valid SHALL pulse exactly one cycle after acceptance, with no response backpressure.
REQ-022 Lane = req_addr[log2(DATA_W/8)-1:0]; word index = remaining upper address bits.
REQ-023 A word access with lane != 0 SHALL not modify memory and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-024 A word write SHALL update all lanes; a byte write SHALL update only the addressed lane with req_wdata[7:0].
REQ-025 A word read SHALL return the whole word; a byte read SHALL return the addressed byte sign-extended to DATA_W.
REQ-026 A write response SHALL have rsp_rdata=0 and rsp_err=0.
REQ-027 A read accepted the cycle after a write to the same word SHALL return the newly written data.
REQ-028 Arithmetic SHALL be unsigned; the init index SHALL stop at DEPTH-1 without wrapping.

Reset
REQ-029 proc_rst=1 SHALL asynchronously force state=INIT, index=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; busy=1; req_ready=0.
REQ-030 Reset asserted mid-INIT or mid-traffic SHALL discard pending responses and restart initialisation at index 0.
REQ-031 Array contents SHALL NOT be reset directly; they become defined only through INIT.

Structure
REQ-032 Shared package mem_pkg SHALL hold the state enum (INIT, IDLE) and the access-size constants (ACC_WORD, ACC_BYTE).
REQ-033 SHALL instantiate sub-module byte_lane_ram (8-bit wide, DEPTH deep, synchronous write-enable and registered read) DATA_W/8 times.

Verification (DATA_W=16, ADDR_W=6)
REQ-034 Release reset -> busy=1 for exactly 32 cycles, then req_ready=1; a word read of addr 0x3E returns 0x0000.
REQ-035 Word write 0xA5F0 to 0x04, then byte read 0x04 -> 0xFFF0; then byte read 0x05 -> 0xFFA5.
REQ-036 Byte write 0x7B to 0x05, then word read 0x04 -> 0x7BF0 on the cycle after acceptance.
REQ-037 Word write to odd address 0x09 -> rsp_err=1; a following word read of 0x08 shows the old value unchanged.
REQ-038 clr and req_valid asserted together in IDLE -> request not accepted, busy=1 for 32 cycles, all words read INIT_VAL afterwards.
REQ-039 Reset asserted at init index 10 -> after release, busy stays high for a full 32 cycles from index 0.
